uart_stim_tx: RTL and testbench

UART_STIM_TX -- requirements
Module: uart_stim_tx

---
 rtl/uart_stim_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_stim_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stim_tx.sv
// rtl/uart_stim_tx.sv - UART stimulus transmitter with entry FIFO and per-entry error injection
module uart_stim_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 3,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1,
    parameter int IDLE_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_parity_err,
    input  logic                          in_framing_err,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   sent_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;

    typedef enum logic [2:0] {IDLE, GAP, START, DATA, PAR, STOP} state_t;

    state_t                state;
    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [EW-1:0]         head;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  head_par;
    logic [DATA_BITS-1:0]  shreg;
    logic                  par_bit;
    logic                  ferr;
    logic [15:0]           cnt;
    logic [3:0]            bit_idx;
    logic                  bit_end;

    assign full     = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign pop      = (state == IDLE) && (fifo_level != '0);
    assign head     = mem[rd_ptr];
    assign bit_end  = (cnt == 16'(CLKS_PER_BIT - 1));
    assign busy     = (state != IDLE);

    // Entry layout: {framing_err, parity_err, data}
    always_comb begin
        head_par = ^head[DATA_BITS-1:0];
        if (PARITY == 2)
            head_par = ~head_par;
        if (PARITY != 0 && head[DATA_BITS])
            head_par = ~head_par;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_framing_err, in_parity_err, in_data};
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // tx is registered and always set together with the state it belongs to
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ferr       <= 1'b0;
            sent_count <= '0;
        end else begin
            if (state == IDLE || bit_end)
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;

            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    bit_idx <= '0;
                    if (pop) begin
                        shreg   <= head[DATA_BITS-1:0];
                        par_bit <= head_par;
                        ferr    <= head[DATA_BITS+1];
                        if (IDLE_BITS == 0) begin
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: if (bit_end) begin
                    if (bit_idx == 4'(IDLE_BITS - 1)) begin
                        state   <= START;
                        tx      <= 1'b0;
                        bit_idx <= '0;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                START: if (bit_end) begin
                    state <= DATA;
                    tx    <= shreg[0];
                    shreg <= shreg >> 1;
                end
                DATA: if (bit_end) begin
                    if (bit_idx == 4'(DATA_BITS - 1)) begin
                        bit_idx <= '0;
                        if (PARITY != 0) begin
                            state <= PAR;
                            tx    <= par_bit;
                        end else begin
                            state <= STOP;
                            tx    <= ~ferr;
                        end
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                PAR: if (bit_end) begin
                    state <= STOP;
                    tx    <= ~ferr;
                end
                STOP: if (bit_end) begin
                    tx <= 1'b1;
                    if (bit_idx == 4'(STOP_BITS - 1)) begin
                        state      <= IDLE;
                        bit_idx    <= '0;
                        sent_count <= sent_count + 16'd1;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_stim_tx.sv
// tb/tb_uart_stim_tx.sv - scoreboard bench for uart_stim_tx (default and odd-parity/2-stop builds)
module tb_uart_stim_tx;
    localparam int CPB = 3;

    typedef struct {
        logic [7:0] d;
        bit         pe;
        bit         fe;
    } entry_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        in_valid, in_parity_err, in_framing_err;
    logic [7:0]  in_data;
    logic        in_ready, tx, busy;
    logic [4:0]  fifo_level;
    logic [15:0] sent_count;

    logic        in_valid2, in_parity_err2, in_framing_err2;
    logic [7:0]  in_data2;
    logic        in_ready2, tx2, busy2;
    logic [4:0]  fifo_level2;
    logic [15:0] sent_count2;

    int     checks = 0;
    int     errors = 0;
    int     exp_sent = 0;
    entry_t sb[$];

    always #5 clk = ~clk;

    uart_stim_tx dut (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_parity_err(in_parity_err), .in_framing_err(in_framing_err),
        .tx(tx), .busy(busy), .fifo_level(fifo_level), .sent_count(sent_count)
    );

    uart_stim_tx #(.PARITY(2), .STOP_BITS(2), .IDLE_BITS(0)) dut2 (
        .clk(clk), .nreset(nreset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .in_parity_err(in_parity_err2), .in_framing_err(in_framing_err2),
        .tx(tx2), .busy(busy2), .fifo_level(fifo_level2), .sent_count(sent_count2)
    );

    // Reference line waveform, one sample per clk, starting right after the pop cycle
    function automatic logic [127:0] model_wave(input logic [7:0] d, input bit pe, input bit fe,
                                                input int idle, input int par, input int stop,
                                                output int len);
        logic [31:0]  bt;
        logic [127:0] w;
        logic         p;
        int           nb;
        int           n;
        bt = '0;
        nb = 0;
        for (int i = 0; i < idle; i++) begin bt[nb] = 1'b1; nb++; end
        bt[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin bt[nb] = d[i]; nb++; end
        if (par != 0) begin
            p = ^d;
            if (par == 2) p = ~p;
            if (pe) p = ~p;
            bt[nb] = p; nb++;
        end
        for (int i = 0; i < stop; i++) begin bt[nb] = (i == 0) ? ~fe : 1'b1; nb++; end
        w = '0;
        n = 0;
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < CPB; c++) begin w[n] = bt[b]; n++; end
        len = n;
        return w;
    endfunction

    task automatic test_reset();
        nreset = 1'b0;
        in_valid = 0; in_data = '0; in_parity_err = 0; in_framing_err = 0;
        in_valid2 = 0; in_data2 = '0; in_parity_err2 = 0; in_framing_err2 = 0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL reset_sent got %0d want 0", sent_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        nreset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input bit pe, input bit fe);
        entry_t       e;
        logic [127:0] expw, got;
        int           len;
        logic         busy_last;
        in_data = d; in_parity_err = pe; in_framing_err = fe; in_valid = 1'b1;
        if (in_ready) sb.push_back('{d, pe, fe});
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL %s_level got %0d want 1", name, fifo_level); end
        e = sb.pop_front();
        expw = model_wave(e.d, e.pe, e.fe, 1, 1, 1, len);
        got = '0;
        busy_last = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            got[i] = tx;
            busy_last = busy;
        end
        checks++; if (got !== expw) begin errors++; $display("FAIL %s_wave got %h want %h", name, got, expw); end
        checks++; if (busy_last !== 1'b1) begin errors++; $display("FAIL %s_busy_last got %b want 1", name, busy_last); end
        @(negedge clk);
        exp_sent++;
        checks++; if (sent_count !== 16'(exp_sent)) begin errors++; $display("FAIL %s_sent got %0d want %0d", name, sent_count, exp_sent); end
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL %s_idle got busy=%b tx=%b want busy=0 tx=1", name, busy, tx); end
    endtask

    task automatic test_back_to_back();
        entry_t       e1, e2;
        logic [127:0] w1, w2, expw, got;
        int           l1, l2;
        in_data = 8'h3C; in_parity_err = 0; in_framing_err = 0; in_valid = 1'b1;
        if (in_ready) sb.push_back('{8'h3C, 1'b0, 1'b0});
        @(negedge clk);
        in_data = 8'hC1;
        if (in_ready) sb.push_back('{8'hC1, 1'b0, 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        e1 = sb.pop_front();
        e2 = sb.pop_front();
        w1 = model_wave(e1.d, e1.pe, e1.fe, 1, 1, 1, l1);
        w2 = model_wave(e2.d, e2.pe, e2.fe, 1, 1, 1, l2);
        expw = w1 | (128'd1 << l1) | (w2 << (l1 + 1));
        got = '0;
        for (int i = 0; i < l1 + 1 + l2; i++) begin
            if (i > 0) @(negedge clk);
            got[i] = tx;
        end
        checks++; if (got !== expw) begin errors++; $display("FAIL b2b_wave got %h want %h", got, expw); end
        @(negedge clk);
        exp_sent += 2;
        checks++; if (sent_count !== 16'(exp_sent)) begin errors++; $display("FAIL b2b_sent got %0d want %0d", sent_count, exp_sent); end
    endtask

    task automatic decode_frame();
        entry_t     e;
        logic [7:0] got;
        logic       gp, gs, wp;
        int         t;
        t = 0;
        while (tx !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL decode_timeout got no start bit want start within 200 cycles");
            return;
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); got[i] = tx; end
        repeat (CPB) @(negedge clk); gp = tx;
        repeat (CPB) @(negedge clk); gs = tx;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL decode_unexpected got frame %h want none", got);
        end else begin
            e = sb.pop_front();
            wp = (^e.d) ^ e.pe;
            checks++; if (got !== e.d) begin errors++; $display("FAIL decode_data got %h want %h", got, e.d); end
            checks++; if (gp !== wp) begin errors++; $display("FAIL decode_parity got %b want %b", gp, wp); end
            checks++; if (gs !== ~e.fe) begin errors++; $display("FAIL decode_stop got %b want %b", gs, ~e.fe); end
        end
        t = 0;
        while (tx !== 1'b1 && t < 10) begin @(negedge clk); t++; end
    endtask

    task automatic test_fifo_fill();
        int accepted = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [7:0] d;
                    d = 8'($urandom_range(0, 255));
                    in_data = d; in_parity_err = 0; in_framing_err = 0; in_valid = 1'b1;
                    checks++;
                    if (in_ready !== (fifo_level != 5'd16)) begin
                        errors++;
                        $display("FAIL fill_ready got %b want %b at level %0d", in_ready, fifo_level != 5'd16, fifo_level);
                    end
                    if (in_ready) begin sb.push_back('{d, 1'b0, 1'b0}); accepted++; end
                    @(negedge clk);
                end
                in_valid = 1'b0;
                checks++; if (accepted != 17) begin errors++; $display("FAIL fill_accepted got %0d want 17", accepted); end
                checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d want 16", fifo_level); end
            end
            begin
                repeat (17) decode_frame();
            end
        join
        exp_sent += 17;
        repeat (4) @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL fill_leftover got %0d want 0", sb.size()); end
        checks++; if (sent_count !== 16'(exp_sent)) begin errors++; $display("FAIL fill_sent got %0d want %0d", sent_count, exp_sent); end
    endtask

    task automatic test_reset_mid_frame();
        bit bad = 0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h70 + i); in_valid = 1'b1;
            if (in_ready) sb.push_back('{8'(8'h70 + i), 1'b0, 1'b0});
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b1 || fifo_level !== 5'd3) begin errors++; $display("FAIL mid_pre got busy=%b level=%0d want busy=1 level=3", busy, fifo_level); end
        nreset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1 || fifo_level !== 5'd0) begin errors++; $display("FAIL mid_abort got tx=%b level=%0d want tx=1 level=0", tx, fifo_level); end
        checks++; if (busy !== 1'b0 || sent_count !== 16'd0) begin errors++; $display("FAIL mid_state got busy=%b sent=%0d want busy=0 sent=0", busy, sent_count); end
        sb.delete();
        exp_sent = 0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 5'd0) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL mid_after got activity after reset want quiet line"); end
    endtask

    task automatic test_par2_stop2();
        entry_t       e;
        logic [127:0] expw, got;
        int           len;
        in_data2 = 8'h00; in_parity_err2 = 0; in_framing_err2 = 0; in_valid2 = 1'b1;
        if (in_ready2) sb.push_back('{8'h00, 1'b0, 1'b0});
        @(negedge clk);
        in_valid2 = 1'b0;
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL p2_popcycle got busy=%b want 0", busy2); end
        e = sb.pop_front();
        expw = model_wave(e.d, e.pe, e.fe, 0, 2, 2, len);
        got = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            got[i] = tx2;
        end
        checks++; if (got !== expw) begin errors++; $display("FAIL p2_wave got %h want %h", got, expw); end
        @(negedge clk);
        checks++; if (sent_count2 !== 16'd1 || busy2 !== 1'b0) begin errors++; $display("FAIL p2_done got sent=%0d busy=%b want sent=1 busy=0", sent_count2, busy2); end
    endtask

    initial begin
        test_reset();
        test_frame("a5", 8'hA5, 1'b0, 1'b0);
        test_frame("perr", 8'h03, 1'b1, 1'b0);
        test_frame("ferr", 8'h55, 1'b0, 1'b1);
        test_back_to_back();
        test_fifo_fill();
        test_reset_mid_frame();
        test_par2_stop2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
